data_mem_ctrl: RTL

- Data-memory controller directly downstream of the load/store queue.
- Accepts tagged load/store requests, buffers them in an in-order request FIFO, and services them against a word-addressed data RAM.
- Stores occupy the RAM port for multiple cycles, which creates real backpressure.
- Returns one tagged response per cycle in request order after a fixed pipeline latency.

---
 rtl/mem_pkg.sv | 15 +
 rtl/req_fifo.sv | 36 +++
 rtl/data_mem_ctrl.sv | 66 ++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: request/response types shared by the data-memory controller and its FIFO
package mem_pkg;
   localparam int LSQ_ID_W = 4;
   localparam int WORD_W   = 32;
   typedef struct packed {
      logic [WORD_W-1:0]   addr;
      logic [WORD_W-1:0]   data;
      logic                rw;
      logic [LSQ_ID_W-1:0] id;
   } mem_req_t;
   typedef struct packed {
      logic [WORD_W-1:0]   data;
      logic [LSQ_ID_W-1:0] id;
   } mem_rsp_t;
endpackage

// File: rtl/req_fifo.sv
// req_fifo: in-order request buffer with a registered occupancy count
module req_fifo
   import mem_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = mem_req_t
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  T                      wr,
   input  logic                  pop,
   output T                      rd,
   output logic [$clog2(DEPTH):0] count,
   output logic                  empty,
   output logic                  full
);
   localparam int PW = $clog2(DEPTH);
   T              slots [DEPTH];
   logic [PW-1:0] wp, rp;
   assign rd    = slots[rp];
   assign empty = count == '0;
   assign full  = count == (PW+1)'(DEPTH);
   always_ff @(posedge clk)
      if (push) slots[wp] <= wr;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (push) wp <= wp + PW'(1);
         if (pop) rp <= rp + PW'(1);
         count <= count + (PW+1)'(push) - (PW+1)'(pop);
      end
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: in-order load/store servicing of a word-addressed data RAM
module data_mem_ctrl
   import mem_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int LAT    = 2,
   parameter int ST_CYC = 2,
   parameter int AW     = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [WORD_W-1:0]   addr_in,
   input  logic [WORD_W-1:0]   data_in,
   input  logic                rw_in,
   input  logic [LSQ_ID_W-1:0] id_in,
   input  logic                valid_in,
   output logic [WORD_W-1:0]   data_out,
   output logic [LSQ_ID_W-1:0] id_out,
   output logic                ready_out,
   output logic                stall_out
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int BW = $clog2(ST_CYC + 1);
   mem_req_t          req, head;
   mem_rsp_t          rsp;
   mem_rsp_t          pipe [LAT];
   logic [LAT-1:0]    pv;
   logic [WORD_W-1:0] ram [2**AW];
   logic [CW-1:0]     count;
   logic [BW-1:0]     busy;
   logic              empty, full, push, issue, unused;
   // stall comes from the registered count only, so a same-cycle pop never lifts it
   assign stall_out = !rst || count == CW'(DEPTH);
   assign push      = valid_in && !stall_out;
   assign issue     = !empty && busy == '0;
   assign req       = '{addr: addr_in, data: data_in, rw: rw_in, id: id_in};
   assign rsp       = '{data: head.rw ? head.data : ram[head.addr[AW+1:2]], id: head.id};
   assign unused    = ^{full, head.addr[WORD_W-1:AW+2], head.addr[1:0]};
   req_fifo #(.DEPTH(DEPTH), .T(mem_req_t)) u_fifo (
      .clk(clk), .rst(rst), .push(push), .wr(req), .pop(issue),
      .rd(head), .count(count), .empty(empty), .full(full)
   );
   always_ff @(posedge clk)
      if (issue && head.rw) ram[head.addr[AW+1:2]] <= head.data;
   always_ff @(posedge clk) begin
      pipe[0] <= rsp;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         busy      <= '0;
         pv        <= '0;
         ready_out <= 1'b0;
         data_out  <= '0;
         id_out    <= '0;
      end else begin
         busy  <= (issue && head.rw) ? BW'(ST_CYC - 1) : busy - BW'(busy != '0);
         pv[0] <= issue;
         for (int i = 1; i < LAT; i++) pv[i] <= pv[i-1];
         ready_out <= pv[LAT-1];
         if (pv[LAT-1]) begin
            data_out <= pipe[LAT-1].data;
            id_out   <= pipe[LAT-1].id;
         end
      end
endmodule
